// File: rtl/ilog2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ilog2_arb_pkg
// Brief    : Shared widths, latency and shadow-entry type for ilog2_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ilog2_arb_pkg;

  localparam int LOG2_LAT = 3;
  localparam int OPND_W   = 32;
  localparam int RES_W    = 5;
  // Sized for the largest supported requester count (16).
  localparam int SHD_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [SHD_ID_W-1:0] id;
    logic                zero;
  } shadow_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; search starts at ptr and wraps N-1 -> 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] ptr
);

  localparam int DW = IW + 1;

  logic [DW-1:0] w_dist;
  logic [DW-1:0] w_best;

  // The requester at the smallest forward distance from ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_best    = DW'(N);
    w_dist    = '0;
    for (int j = 0; j < N; j++) begin
      w_dist = DW'(j) + DW'(N) - {1'b0, ptr};
      if (w_dist >= DW'(N)) begin
        w_dist = w_dist - DW'(N);
      end
      if (req[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && (|grant)) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ilog2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ilog2_arbiter
// Brief    : Shares one pipelined ilog2 unit among N_REQ requesters and routes
//            each result back with a one-hot strobe. ILOG2_ARB_PERF_EN adds
//            saturating grant / conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module ilog2_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int LOG2_LAT = ilog2_arb_pkg::LOG2_LAT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [ilog2_arb_pkg::OPND_W*N_REQ-1:0] req_value,
  output logic [N_REQ-1:0]                      req_ready,
  output logic [N_REQ-1:0]                      rsp_valid,
  output logic [ilog2_arb_pkg::RES_W-1:0]       rsp_log2,
  output logic                                  rsp_zero,
  output logic                                  busy,
  output logic [ilog2_arb_pkg::OPND_W-1:0]      lg_v,
  input  logic [ilog2_arb_pkg::RES_W-1:0]       lg_log2
`ifdef ILOG2_ARB_PERF_EN
  ,
  output logic [32*N_REQ-1:0]                   perf_grants,
  output logic [31:0]                           perf_conflict
`endif
);

  import ilog2_arb_pkg::*;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_idx;
  logic [ID_W-1:0]  w_ptr;
  logic             w_unused_ptr;
  logic             w_grant_any;
  logic             w_opnd_zero;
  shadow_t          r_shd [LOG2_LAT];
  shadow_t          w_tail;
  logic [N_REQ-1:0] w_rsp_hot;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .advance   (w_grant_any),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .ptr       (w_ptr)
  );

  assign w_unused_ptr = ^w_ptr;
  assign req_ready    = w_grant;
  assign w_grant_any  = |w_grant;

  always_comb begin
    lg_v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        lg_v = req_value[OPND_W*i +: OPND_W];
      end
    end
  end

  assign w_opnd_zero = (lg_v == '0);

  // Shadow pipeline tracks the ilog2 core stage-for-stage; it never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LOG2_LAT; s++) begin
        r_shd[s] <= '0;
      end
    end else begin
      r_shd[0] <= '{valid: w_grant_any,
                    id:    SHD_ID_W'(w_grant_idx),
                    zero:  w_opnd_zero};
      for (int s = 1; s < LOG2_LAT; s++) begin
        r_shd[s] <= r_shd[s-1];
      end
    end
  end

  assign w_tail = r_shd[LOG2_LAT-1];

  always_comb begin
    w_rsp_hot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_tail.valid && (w_tail.id == SHD_ID_W'(i))) begin
        w_rsp_hot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_log2  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      rsp_valid <= w_rsp_hot;
      if (w_tail.valid) begin
        rsp_log2 <= lg_log2;
        rsp_zero <= w_tail.zero;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LOG2_LAT; s++) begin
      busy = busy | r_shd[s].valid;
    end
  end

`ifdef ILOG2_ARB_PERF_EN
  logic        w_conflict;
  logic [31:0] r_conflict;

  assign w_conflict = ($countones(req_valid) > 1);

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_perf_grant
      logic [31:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_grant[i] && (r_cnt != 32'hFFFF_FFFF)) begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
      assign perf_grants[32*i +: 32] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict <= '0;
    end else if (w_conflict && (r_conflict != 32'hFFFF_FFFF)) begin
      r_conflict <= r_conflict + 32'd1;
    end
  end

  assign perf_conflict = r_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ilog2_arbiter.sv
`default_nettype none
// Bench for ilog2_arbiter: directed scenarios plus random traffic, checked
// through an expected-response queue against a spec-level arbitration model.
module tb_ilog2_arbiter;

  localparam int N_REQ = 4;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [32*N_REQ-1:0]   req_value;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      rsp_valid;
  logic [4:0]            rsp_log2;
  logic                  rsp_zero;
  logic                  busy;
  logic [31:0]           lg_v;
  logic [4:0]            lg_log2;

  ilog2_arbiter #(.N_REQ(N_REQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_value (req_value),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_log2  (rsp_log2),
    .rsp_zero  (rsp_zero),
    .busy      (busy),
    .lg_v      (lg_v),
    .lg_log2   (lg_log2)
  );

  always #5 clk = ~clk;

  function automatic int flog2(input logic [31:0] v);
    int r;
    logic [31:0] x;
    r = 0;
    x = v;
    while (x > 32'd1) begin
      x = x >> 1;
      r++;
    end
    return r;
  endfunction

  // Stand-in for the shared ilog2 core: samples lg_v, result after LAT edges.
  logic [4:0] core_pipe [LAT];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) core_pipe[s] <= 5'd0;
    end else begin
      core_pipe[0] <= 5'(flog2(lg_v));
      for (int s = 1; s < LAT; s++) core_pipe[s] <= core_pipe[s-1];
    end
  end
  assign lg_log2 = core_pipe[LAT-1];

  typedef struct {
    int id;
    int lg;
    bit zero;
    int due;
  } exp_t;

  exp_t             sb [$];
  logic [31:0]      pend [N_REQ][$];
  logic [N_REQ-1:0] granted = '0;
  int               mptr = 0;
  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [4:0]       last_log2 = 5'd0;
  logic             last_zero = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arbitration: first valid requester at or after the model pointer.
  always @(negedge clk) begin
    int win;
    int j;
    logic [N_REQ-1:0] exp_ready;
    logic [31:0] v;
    if (reset) begin
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rsp_log2", 32'(rsp_log2), 0);
      sb.delete();
      mptr = 0;
      granted = '0;
    end else begin
      win = -1;
      for (int k = 0; k < N_REQ; k++) begin
        j = (mptr + k) % N_REQ;
        if (win < 0 && req_valid[j[1:0]]) win = j;
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win[1:0]] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (win >= 0) begin
        v = req_value[32*win +: 32];
        chk("lg_v", lg_v, v);
        sb.push_back('{id: win, lg: flog2(v), zero: (v == 32'd0), due: cyc + LAT + 1});
        mptr = (win + 1) % N_REQ;
      end else begin
        chk("lg_v_idle", lg_v, 0);
      end
      granted = exp_ready;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (reset) begin
      last_log2 = 5'd0;
      last_zero = 1'b0;
    end else begin
      exp_busy = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].due - LAT <= cyc && cyc <= sb[i].due - 1) exp_busy = 1'b1;
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
          chk("rsp_log2", 32'(rsp_log2), e.lg);
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          last_log2 = 5'(e.lg);
          last_zero = e.zero;
        end
      end else begin
        chk("hold_log2", 32'(rsp_log2), 32'(last_log2));
        chk("hold_zero", 32'(rsp_zero), 32'(last_zero));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("rsp_missing", 32'(rsp_valid), 32'(1) << sb[0].id);
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic int pending_count();
    int n;
    n = 0;
    for (int i = 0; i < N_REQ; i++) n += pend[i].size();
    return n;
  endfunction

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_value[32*i +: 32] = pend[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_value[32*i +: 32] = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (granted[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && pending_count() > 0; c++) begin
      tick();
      drive();
    end
    chk("drain_timeout", pending_count(), 0);
    repeat (LAT + 3) begin
      tick();
      drive();
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd1 << $urandom_range(0, 31);
      2:       return $urandom;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_value = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // single request, then zero operand
    pend[2].push_back(32'h0000_1000);
    drive();
    drain();
    pend[0].push_back(32'd0);
    drive();
    drain();

    // all requesters held valid for two rounds
    for (int r = 0; r < 2; r++) begin
      pend[0].push_back(32'd1);
      pend[1].push_back(32'd255);
      pend[2].push_back(32'd65536);
      pend[3].push_back(32'h8000_0000);
    end
    drive();
    drain();

    // pointer wrap after a grant to requester 3
    pend[3].push_back(32'd7);
    drive();
    tick();
    pend[1].push_back(32'd9);
    pend[3].push_back(32'd100);
    drive();
    drain();

    // back-to-back from one requester
    pend[1].push_back(32'd2);
    pend[1].push_back(32'd3);
    pend[1].push_back(32'd1024);
    drive();
    drain();

    // reset one cycle after two grants discards them and clears the pointer
    pend[0].push_back(32'd5);
    pend[1].push_back(32'd6);
    drive();
    tick();
    drive();
    tick();
    drive();
    tick();
    reset = 1'b1;
    drive();
    repeat (2) tick();
    reset = 1'b0;
    pend[0].push_back(32'd11);
    pend[3].push_back(32'd12);
    drive();
    drain();

    // random traffic with occasional withdrawals and bursts
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (pend[i].size() == 0) begin
          if ($urandom_range(0, 2) == 0) pend[i].push_back(rand_val());
        end else if ($urandom_range(0, 31) == 0) begin
          pend[i].delete();
        end
        if ($urandom_range(0, 15) == 0) pend[i].push_back(rand_val());
      end
      drive();
    end
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
